sram_bus_arbiter: RTL and testbench

//  Shares one sram-like memory port between the CPU instruction-fetch requester (read-only) and
//  the data requester (read/write with byte strobes). Sits between the mips core and the memory

---
 rtl/sram_bus_pkg.sv | 29 ++
 rtl/sram_bus_arbiter_arb_pick.sv | 90 +++++++++
 rtl/sram_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bus_pkg.sv
// Shared definitions for the single-port SRAM bus arbiter.
// The FSM state encodings stay plain localparams so that existing code
// compares against the same bit patterns. The owner tag is an enum, and a
// helper function derives the byte-strobe width from the data width.
// Optional feature macro used by this slice: ARB_ROUND_ROBIN_EN.
package sram_bus_pkg;

    // Transaction FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;  // waiting for a request
    localparam logic [1:0] ST_ADDR = 2'd1;  // presenting mem_req downstream
    localparam logic [1:0] ST_WAIT = 2'd2;  // waiting for mem_data_ok

    // Which requester owns the outstanding transaction
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_e;

    // Default bus geometry
    localparam int DEF_DATA_W = 32;
    localparam int DEF_STRB_W = DEF_DATA_W / 8;

    // Byte-strobe width for a given data width
    function automatic int strb_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/sram_bus_arbiter_arb_pick.sv
// arb_pick: chooses which requester gets the memory port when the arbiter is
// idle, and keeps the bookkeeping needed to stay fair.
//   default build          : data has priority. A saturating starvation counter
//                            lets inst win once data has been granted
//                            STARVE_LIMIT times in a row while inst was waiting.
//   ARB_ROUND_ROBIN_EN set : on a tie the requester granted most recently loses.
module arb_pick
    import sram_bus_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic inst_req,
    input  logic data_req,
    input  logic grant_en,   // arbiter is idle and out of reset
    output logic pick_inst,
    output logic pick_data
);

`ifdef ARB_ROUND_ROBIN_EN

    // 1 when inst received the most recent grant. Reset to 1 so that data wins
    // the first tie after reset.
    logic last_inst;

    // Round-robin winner selection
    always_comb begin
        // NOTE: every output of a combinational block is given a default first,
        //       so no path can leave it unassigned and infer a latch.
        pick_inst = 1'b0;
        pick_data = 1'b0;
        if (grant_en) begin
            if (inst_req && data_req) begin
                if (last_inst) pick_data = 1'b1;
                else           pick_inst = 1'b1;
            end else if (inst_req) begin
                pick_inst = 1'b1;
            end else if (data_req) begin
                pick_data = 1'b1;
            end
        end
    end

    // Remember who was granted last
    always_ff @(posedge clk) begin
        // NOTE: clocked state is always updated with non-blocking assignments,
        //       so every flop samples values from before the edge.
        if (!resetn)        last_inst <= 1'b1;
        else if (pick_inst) last_inst <= 1'b1;
        else if (pick_data) last_inst <= 1'b0;
    end

`else

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic       inst_turn;

    assign inst_turn = (starve_cnt == LIMIT);

    // Fixed data priority, overridden once inst has waited long enough
    always_comb begin
        // NOTE: every output of a combinational block is given a default first,
        //       so no path can leave it unassigned and infer a latch.
        pick_inst = 1'b0;
        pick_data = 1'b0;
        if (grant_en) begin
            if (data_req && !(inst_req && inst_turn)) pick_data = 1'b1;
            else if (inst_req)                        pick_inst = 1'b1;
        end
    end

    // Count data grants taken while inst waits; clear when inst is served
    always_ff @(posedge clk) begin
        // NOTE: clocked state is always updated with non-blocking assignments,
        //       so every flop samples values from before the edge.
        if (!resetn) begin
            starve_cnt <= '0;
        end else if (pick_inst) begin
            starve_cnt <= '0;
        end else if (pick_data && inst_req && !inst_turn) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

`endif

endmodule

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one sram-like memory port between the instruction
// fetch requester (read-only) and the data requester (read/write with byte
// strobes). Only one transaction is in flight at a time:
//   IDLE -> (grant, addr_ok pulse) -> ADDR -> (mem_addr_ok) -> WAIT
//        -> (mem_data_ok, owner's data_ok pulse) -> IDLE
// Every response output is gated by resetn, so a transaction cut off by
// reset never produces a data_ok.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin pick instead of
// data priority with a starvation limit).
module sram_bus_arbiter
    import sram_bus_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                resetn,
    // instruction fetch port
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    // data port
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    // downstream memory port
    output logic                mem_req,
    output logic                mem_wr,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_addr_ok,
    input  logic                mem_data_ok,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int STRB_W = strb_width(DATA_W);

    logic [1:0]        state;
    owner_e            owner;
    logic              lat_wr;
    logic [STRB_W-1:0] lat_wstrb;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic grant_en;
    logic pick_inst;
    logic pick_data;
    logic in_addr;
    logic resp_fire;

    assign grant_en = resetn && (state == ST_IDLE);

    arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb_pick (
        .clk       (clk),
        .resetn    (resetn),
        .inst_req  (inst_req),
        .data_req  (data_req),
        .grant_en  (grant_en),
        .pick_inst (pick_inst),
        .pick_data (pick_data)
    );

    // Acceptance pulses come straight from the pick in the grant cycle
    assign inst_addr_ok = pick_inst;
    assign data_addr_ok = pick_data;

    // Downstream request: the latched fields, driven only while in ADDR
    assign in_addr   = resetn && (state == ST_ADDR);
    assign mem_req   = in_addr;
    assign mem_wr    = in_addr && lat_wr;
    assign mem_wstrb = in_addr ? lat_wstrb : '0;
    assign mem_addr  = in_addr ? lat_addr  : '0;
    assign mem_wdata = in_addr ? lat_wdata : '0;

    // Response: routed to the owner only; mem_data_ok outside WAIT is ignored
    assign resp_fire    = resetn && (state == ST_WAIT) && mem_data_ok;
    assign inst_data_ok = resp_fire && (owner == OWN_INST);
    assign data_data_ok = resp_fire && (owner == OWN_DATA);
    assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
    assign data_rdata   = data_data_ok ? mem_rdata : '0;

    // Transaction FSM and owner tracking
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
            owner <= OWN_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_inst) begin
                        state <= ST_ADDR;
                        owner <= OWN_INST;
                    end else if (pick_data) begin
                        state <= ST_ADDR;
                        owner <= OWN_DATA;
                    end
                end
                ST_ADDR: begin
                    if (mem_addr_ok) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_data_ok) begin
                        state <= ST_IDLE;
                        owner <= OWN_NONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    owner <= OWN_NONE;
                end
            endcase
        end
    end

    // Capture the granted request so mem_* stays stable while mem_req waits
    always_ff @(posedge clk) begin
        // NOTE: the request latch carries no reset; its contents only reach
        //       the outputs while in ADDR, which is always preceded by a grant.
        if (pick_inst) begin
            lat_wr    <= 1'b0;
            lat_wstrb <= '0;
            lat_addr  <= inst_addr;
            lat_wdata <= '0;
        end else if (pick_data) begin
            lat_wr    <= data_wr;
            lat_wstrb <= data_wr ? data_wstrb : '0;
            lat_addr  <= data_addr;
            lat_wdata <= data_wdata;
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter. A memory model answers mem_req
// with a programmable address-phase delay. Each grant pushes the expected
// downstream request and the expected response into scoreboard queues. These
// entries are popped and compared when the DUT presents mem_req or a data_ok.
module tb_sram_bus_arbiter;
    import sram_bus_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic          inst_addr_ok, inst_data_ok;
    logic [DW-1:0] inst_rdata;
    logic          data_req, data_wr;
    logic [SW-1:0] data_wstrb;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          data_addr_ok, data_data_ok;
    logic [DW-1:0] data_rdata;
    logic          mem_req, mem_wr;
    logic [SW-1:0] mem_wstrb;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_addr_ok, mem_data_ok;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic          wr;
        logic [SW-1:0] wstrb;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit            chk_wdata;
    } mem_exp_t;

    typedef struct {
        owner_e        who;
        logic [DW-1:0] rdata;
        int            cyc;
    } resp_exp_t;

    mem_exp_t  mem_q[$];
    resp_exp_t resp_q[$];

    // Memory contents as seen by the model
    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        if (a == 32'hBFC0_0000) return 32'h2401_0001;
        return a ^ 32'hA5A5_5A5A;
    endfunction

    // Memory model controls; manual mode lets a test drive the handshake itself
    int            cyc = 0;
    bit            auto_mem = 1'b1;
    int            addr_delay = 0;
    logic          mdl_addr_ok = 1'b0, mdl_data_ok = 1'b0;
    logic [DW-1:0] mdl_rdata = '0;
    logic          man_addr_ok = 1'b0, man_data_ok = 1'b0;
    logic [DW-1:0] man_rdata = '0;

    assign mem_addr_ok = auto_mem ? mdl_addr_ok : man_addr_ok;
    assign mem_data_ok = auto_mem ? mdl_data_ok : man_data_ok;
    assign mem_rdata   = auto_mem ? mdl_rdata   : man_rdata;

    // Memory model plus response monitor
    initial begin
        int            wait_cnt;
        bit            pend;
        logic [DW-1:0] pend_rdata;
        resp_exp_t     r;
        wait_cnt = 0;
        pend = 1'b0;
        pend_rdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            mdl_addr_ok = 1'b0;
            mdl_data_ok = 1'b0;
            mdl_rdata   = '0;
            if (!auto_mem) begin
                wait_cnt = 0;
                pend = 1'b0;
            end else if (pend) begin
                mdl_data_ok = 1'b1;
                mdl_rdata   = pend_rdata;
                pend = 1'b0;
            end else if (mem_req) begin
                if (mem_q.size() == 0) begin
                    check("mem_unexpected_req", 1'b1, 1'b0);
                end else begin
                    check("mem_addr",  mem_addr,  mem_q[0].addr);
                    check("mem_wr",    mem_wr,    mem_q[0].wr);
                    check("mem_wstrb", mem_wstrb, mem_q[0].wstrb);
                    if (mem_q[0].chk_wdata) check("mem_wdata", mem_wdata, mem_q[0].wdata);
                end
                if (wait_cnt >= addr_delay) begin
                    mdl_addr_ok = 1'b1;
                    wait_cnt = 0;
                    pend = 1'b1;
                    pend_rdata = mem_fn(mem_addr);
                    if (mem_q.size() != 0) void'(mem_q.pop_front());
                end else begin
                    wait_cnt++;
                end
            end
            #1;
            if (inst_data_ok || data_data_ok) begin
                check("dok_exclusive", inst_data_ok & data_data_ok, 1'b0);
                if (resp_q.size() == 0) begin
                    check("dok_unexpected", 1'b1, 1'b0);
                end else begin
                    r = resp_q.pop_front();
                    check("dok_owner", inst_data_ok ? OWN_INST : OWN_DATA, r.who);
                    check("dok_rdata", inst_data_ok ? inst_rdata : data_rdata, r.rdata);
                    check("dok_cycle", cyc, r.cyc);
                end
            end
        end
    end

    // Record the expected downstream request and response for a grant
    task automatic note_grant(input owner_e who, input int dly);
        if (who == OWN_INST) begin
            mem_q.push_back('{1'b0, '0, inst_addr, '0, 1'b0});
            resp_q.push_back('{OWN_INST, mem_fn(inst_addr), cyc + 2 + dly});
        end else begin
            mem_q.push_back('{data_wr, data_wr ? data_wstrb : '0, data_addr, data_wdata, 1'b1});
            resp_q.push_back('{OWN_DATA, mem_fn(data_addr), cyc + 2 + dly});
        end
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 40 && resp_q.size() != 0; k++) @(negedge clk);
        check(tag, resp_q.size(), 0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        resetn = 1'b0;
        inst_req = 1'b0;
        data_req = 1'b0;
        @(negedge clk);
        #2;
        check("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
        check("rst_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
        check("rst_rdata",   {inst_rdata, data_rdata}, 64'h0);
        check("rst_mem_ctl", {mem_req, mem_wr, mem_wstrb}, 6'h0);
        check("rst_mem_dp",  {mem_addr, mem_wdata}, 64'h0);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // Issue a single request and wait (bounded) for the grant and response
    task automatic run_txn(input string tag, input bit is_data, input logic wr,
                           input logic [SW-1:0] strb, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, output int grant_t);
        bit got;
        got = 1'b0;
        grant_t = -1;
        @(negedge clk);
        if (is_data) begin
            data_req = 1'b1; data_wr = wr; data_wstrb = strb;
            data_addr = addr; data_wdata = wdata;
        end else begin
            inst_req = 1'b1; inst_addr = addr;
        end
        for (int t = 0; t < 20 && !got; t++) begin
            #2;
            if (is_data ? data_addr_ok : inst_addr_ok) begin
                got = 1'b1;
                grant_t = t;
                check({tag, "_other_grant"}, is_data ? inst_addr_ok : data_addr_ok, 1'b0);
                note_grant(is_data ? OWN_DATA : OWN_INST, addr_delay);
            end
            @(negedge clk);
            if (got) begin
                inst_req = 1'b0;
                data_req = 1'b0;
            end
        end
        if (!got) check({tag, "_grant_timeout"}, 1'b0, 1'b1);
        drain({tag, "_drain"});
    endtask

    initial begin
        int  gt;
        int  n_grants;
        int  last_c;
        bit  exp_data;
        resetn = 1'b0;
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0;
        data_addr = '0; data_wdata = '0;

        reset_dut();

        // Boot fetch, minimum latency
        run_txn("t1", 1'b0, 1'b0, '0, 32'hBFC0_0000, '0, gt);
        check("t1_grant_c0", gt, 0);

        // Data write with partial strobes
        run_txn("t2w", 1'b1, 1'b1, 4'h3, 32'h8000_1000, 32'h0000_1234, gt);
        check("t2w_grant_c0", gt, 0);

        // Data read: strobes must not reach the memory
        run_txn("t2r", 1'b1, 1'b0, 4'hF, 32'h8000_1004, 32'h5555_AAAA, gt);

        // Slow address phase, with an inst request waiting behind it
        addr_delay = 3;
        @(negedge clk);
        data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hC;
        data_addr = 32'h8000_2000; data_wdata = 32'hCAFE_F00D;
        #2;
        check("t5_grant", data_addr_ok, 1'b1);
        note_grant(OWN_DATA, 3);
        @(negedge clk);
        data_req = 1'b0;
        inst_req = 1'b1; inst_addr = 32'hBFC0_0040;
        for (int c = 0; c < 5; c++) begin
            #2;
            check("t5_no_second_grant", inst_addr_ok, 1'b0);
            check("t5_mem_req_held", mem_req, (c < 4) ? 1'b1 : 1'b0);
            @(negedge clk);
        end
        addr_delay = 0;
        #2;
        check("t5_inst_grant_after", inst_addr_ok, 1'b1);
        if (inst_addr_ok) note_grant(OWN_INST, 0);
        @(negedge clk);
        inst_req = 1'b0;
        drain("t5_drain");

        // Both requesters held continuously
        reset_dut();
        @(negedge clk);
        inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
        data_req = 1'b1; data_wr = 1'b0; data_wstrb = 4'hF;
        data_addr = 32'h8000_3000; data_wdata = 32'hDEAD_0000;
        n_grants = 0;
        last_c = 0;
        for (int c = 0; c < 60 && n_grants < 10; c++) begin
            #2;
            if (inst_addr_ok || data_addr_ok) begin
`ifdef ARB_ROUND_ROBIN_EN
                exp_data = (n_grants % 2) == 0;
`else
                exp_data = (n_grants % 5) != 4;
`endif
                check("t3_grant_data", data_addr_ok, exp_data);
                check("t3_grant_inst", inst_addr_ok, !exp_data);
                if (n_grants > 0) check("t3_spacing", c - last_c, 3);
                note_grant(data_addr_ok ? OWN_DATA : OWN_INST, 0);
                last_c = c;
                n_grants++;
            end
            @(negedge clk);
        end
        check("t3_grant_count", n_grants, 10);
        inst_req = 1'b0;
        data_req = 1'b0;
        drain("t3_drain");

        // Reset while waiting for the response
        auto_mem = 1'b0;
        @(negedge clk);
        inst_req = 1'b1; inst_addr = 32'hBFC0_0200;
        #2;
        check("t6_grant", inst_addr_ok, 1'b1);
        @(negedge clk);
        inst_req = 1'b0;
        man_addr_ok = 1'b1;
        #2;
        check("t6_mem_req", mem_req, 1'b1);
        @(negedge clk);
        man_addr_ok = 1'b0;
        resetn = 1'b0;
        man_data_ok = 1'b1;
        man_rdata = 32'hFFFF_FFFF;
        #2;
        check("t6_no_dok_in_reset", {inst_data_ok, data_data_ok}, 2'b00);
        check("t6_rdata_in_reset", inst_rdata, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        #2;
        check("t6_idle_no_dok", {inst_data_ok, data_data_ok}, 2'b00);
        check("t6_idle_mem", {mem_req, mem_wr, mem_addr}, 34'h0);
        check("t6_idle_rdata", {inst_rdata, data_rdata}, 64'h0);
        @(negedge clk);
        man_data_ok = 1'b0;
        auto_mem = 1'b1;
        run_txn("t6_after", 1'b0, 1'b0, '0, 32'hBFC0_0000, '0, gt);
        check("t6_after_grant_c0", gt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global bound on the run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
